// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU plus an iterative 32-step multiply/divide unit feeding HI/LO,
// registered into the EX/MEM boundary. Stalls upstream while the multiply/divide unit is busy.
module ex_muldiv_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     iInstr,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    input  logic [XLEN-1:0] ioutSignEXT,
    input  logic            iALUSrc,
    input  logic [3:0]      iALUCtrl,
    input  logic            iRegWrite,
    input  logic            iMemRead,
    input  logic            iMemWrite,
    input  logic            iMemToReg,
    input  logic [4:0]      iwriteRegWire,
    input  logic            ivalid,
    input  logic            iflush,
    output logic [31:0]     oInstr,
    output logic [XLEN-1:0] oALUResult,
    output logic            oZero,
    output logic [XLEN-1:0] oB,
    output logic [4:0]      owriteRegWire,
    output logic            oRegWrite,
    output logic            oMemRead,
    output logic            oMemWrite,
    output logic            oMemToReg,
    output logic            ovalid,
    output logic            ostall
);

    localparam int CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

    stateT             stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [XLEN-1:0]   accHiQ, accHiD, accLoQ, accLoD, mcandQ, mcandD;
    logic              mulQ, mulD, negLoQ, negLoD, negHiQ, negHiD, divZeroQ, divZeroD;
    logic [XLEN-1:0]   hiQ, loQ, hiD, loD;
    logic              hiloWe;

    // Decode
    logic [5:0] opcode, funct;
    logic       isRType, isMd, isMfhi, isMflo, mdSigned, aNeg, bNeg;
    logic [XLEN-1:0] aMag, bMag;

    assign opcode   = iInstr[31:26];
    assign funct    = iInstr[5:0];
    assign isRType  = (opcode == 6'h00);
    assign isMd     = isRType && (funct[5:2] == 4'b0110);
    assign isMfhi   = isRType && (funct == 6'h10);
    assign isMflo   = isRType && (funct == 6'h12);
    assign mdSigned = ~funct[0];
    assign aNeg     = mdSigned & iA[XLEN-1];
    assign bNeg     = mdSigned & iB[XLEN-1];
    assign aMag     = aNeg ? (~iA + 1'b1) : iA;
    assign bMag     = bNeg ? (~iB + 1'b1) : iB;

    // One iteration of each algorithm
    logic [XLEN:0]     mulSum, divShift, divDiff;
    logic [2*XLEN:0]   mulShift;
    logic [XLEN-1:0]   stepHi, stepLo;

    assign mulSum   = accLoQ[0] ? ({1'b0, accHiQ} + {1'b0, mcandQ}) : {1'b0, accHiQ};
    assign mulShift = {mulSum, accLoQ} >> 1;
    assign divShift = {accHiQ, accLoQ[XLEN-1]};
    assign divDiff  = divShift - {1'b0, mcandQ};

    always_comb begin
        stepHi = '0;
        stepLo = '0;
        if (mulQ) begin
            stepHi = mulShift[2*XLEN-1:XLEN];
            stepLo = mulShift[XLEN-1:0];
        end else if (!divDiff[XLEN]) begin
            stepHi = divDiff[XLEN-1:0];
            stepLo = {accLoQ[XLEN-2:0], 1'b1};
        end else begin
            stepHi = divShift[XLEN-1:0];
            stepLo = {accLoQ[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction applied as the result is committed to HI/LO
    logic [2*XLEN-1:0] prod;
    assign prod = negLoQ ? (~{accHiQ, accLoQ} + 1'b1) : {accHiQ, accLoQ};

    always_comb begin
        hiD = hiQ;
        loD = loQ;
        if (mulQ) begin
            hiD = prod[2*XLEN-1:XLEN];
            loD = prod[XLEN-1:0];
        end else begin
            hiD = negHiQ ? (~accHiQ + 1'b1) : accHiQ;
            loD = divZeroQ ? '1 : (negLoQ ? (~accLoQ + 1'b1) : accLoQ);
        end
    end

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        accHiD   = accHiQ;
        accLoD   = accLoQ;
        mcandD   = mcandQ;
        mulD     = mulQ;
        negLoD   = negLoQ;
        negHiD   = negHiQ;
        divZeroD = divZeroQ;
        ostall   = 1'b0;
        hiloWe   = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (ivalid && isMd && !iflush) begin
                    ostall   = 1'b1;
                    stateD   = StBusy;
                    cntD     = '0;
                    mulD     = ~funct[1];
                    accHiD   = '0;
                    accLoD   = funct[1] ? aMag : bMag;
                    mcandD   = funct[1] ? bMag : aMag;
                    negLoD   = aNeg ^ bNeg;
                    negHiD   = funct[1] ? aNeg : (aNeg ^ bNeg);
                    divZeroD = funct[1] && (iB == '0);
                end
            end
            StBusy: begin
                if (iflush) begin
                    stateD = StIdle;
                end else begin
                    ostall = 1'b1;
                    accHiD = stepHi;
                    accLoD = stepLo;
                    cntD   = cntQ + 1'b1;
                    if (cntQ == CntW'(XLEN - 1)) stateD = StDone;
                end
            end
            StDone: begin
                stateD = StIdle;
                hiloWe = ~iflush;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            accHiQ   <= '0;
            accLoQ   <= '0;
            mcandQ   <= '0;
            mulQ     <= 1'b0;
            negLoQ   <= 1'b0;
            negHiQ   <= 1'b0;
            divZeroQ <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            accHiQ   <= accHiD;
            accLoQ   <= accLoD;
            mcandQ   <= mcandD;
            mulQ     <= mulD;
            negLoQ   <= negLoD;
            negHiQ   <= negHiD;
            divZeroQ <= divZeroD;
            if (hiloWe) begin
                hiQ <= hiD;
                loQ <= loD;
            end
        end
    end

    // Single-cycle ALU; mfhi/mflo override the ALU control
    logic [XLEN-1:0] aluB, aluResult;

    assign aluB = iALUSrc ? ioutSignEXT : iB;

    always_comb begin
        aluResult = '0;
        case (iALUCtrl)
            4'b0000: aluResult = iA & aluB;
            4'b0001: aluResult = iA | aluB;
            4'b0010: aluResult = iA + aluB;
            4'b0110: aluResult = iA - aluB;
            4'b0111: aluResult = {{(XLEN-1){1'b0}}, ($signed(iA) < $signed(aluB))};
            4'b1100: aluResult = ~(iA | aluB);
            default: aluResult = '0;
        endcase
        if (isMfhi) aluResult = hiQ;
        else if (isMflo) aluResult = loQ;
    end

    logic bubble;
    assign bubble = ostall | iflush | ~ivalid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oInstr        <= '0;
            oALUResult    <= '0;
            oZero         <= 1'b0;
            oB            <= '0;
            owriteRegWire <= '0;
            oRegWrite     <= 1'b0;
            oMemRead      <= 1'b0;
            oMemWrite     <= 1'b0;
            oMemToReg     <= 1'b0;
            ovalid        <= 1'b0;
        end else if (bubble) begin
            oInstr        <= '0;
            owriteRegWire <= '0;
            oRegWrite     <= 1'b0;
            oMemRead      <= 1'b0;
            oMemWrite     <= 1'b0;
            oMemToReg     <= 1'b0;
            ovalid        <= 1'b0;
        end else begin
            oInstr        <= iInstr;
            oALUResult    <= aluResult;
            oZero         <= (aluResult == '0);
            oB            <= iB;
            owriteRegWire <= iwriteRegWire;
            // A retiring multiply/divide writes HI/LO only, never the register file
            oRegWrite     <= iRegWrite & (stateQ != StDone);
            oMemRead      <= iMemRead;
            oMemWrite     <= iMemWrite;
            oMemToReg     <= iMemToReg;
            ovalid        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed-vector bench for ex_muldiv_stage: ALU ops, bubbles, flushes, MD latency,
// signed/unsigned multiply/divide, divide by zero and asynchronous reset mid-operation.
module tb_ex_muldiv_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iInstr, iA, iB, ioutSignEXT;
    logic        iALUSrc;
    logic [3:0]  iALUCtrl;
    logic        iRegWrite, iMemRead, iMemWrite, iMemToReg;
    logic [4:0]  iwriteRegWire;
    logic        ivalid, iflush;
    logic [31:0] oInstr, oALUResult, oB;
    logic        oZero;
    logic [4:0]  owriteRegWire;
    logic        oRegWrite, oMemRead, oMemWrite, oMemToReg, ovalid, ostall;

    int testsRun = 0;
    int testsFailed = 0;

    ex_muldiv_stage #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .iInstr(iInstr), .iA(iA), .iB(iB),
        .ioutSignEXT(ioutSignEXT), .iALUSrc(iALUSrc), .iALUCtrl(iALUCtrl),
        .iRegWrite(iRegWrite), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
        .iMemToReg(iMemToReg), .iwriteRegWire(iwriteRegWire), .ivalid(ivalid),
        .iflush(iflush), .oInstr(oInstr), .oALUResult(oALUResult), .oZero(oZero),
        .oB(oB), .owriteRegWire(owriteRegWire), .oRegWrite(oRegWrite),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemToReg(oMemToReg),
        .ovalid(ovalid), .ostall(ostall)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] MULT  = 32'h0085_0018;
    localparam logic [31:0] MULTU = 32'h0085_0019;
    localparam logic [31:0] DIV   = 32'h0085_001A;
    localparam logic [31:0] DIVU  = 32'h0085_001B;
    localparam logic [31:0] MFHI  = 32'h0000_1010;
    localparam logic [31:0] MFLO  = 32'h0000_1012;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setIn(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [3:0] ctrl,
                         input logic rw, input logic mr, input logic mw, input logic m2r,
                         input logic [4:0] wr, input logic valid);
        iInstr = instr; iA = a; iB = b; ioutSignEXT = imm; iALUSrc = src; iALUCtrl = ctrl;
        iRegWrite = rw; iMemRead = mr; iMemWrite = mw; iMemToReg = m2r;
        iwriteRegWire = wr; ivalid = valid;
    endtask

    // Single-cycle op: no stall expected, then step one edge
    task automatic stepAlu(input string tag);
        @(negedge clock);
        check({tag, " stall"}, {31'b0, ostall}, 32'd0);
        @(posedge clock); #1;
    endtask

    // Present an MD op just after an edge; expect 33 stall cycles and retire at E0+34
    task automatic doMd(input string tag, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b);
        int stalls;
        setIn(instr, a, b, 32'h0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ostall) stalls++;
            else break;
        end
        check({tag, " stall cycles"}, stalls, 33);
        @(posedge clock); #1;
        check({tag, " ovalid"}, {31'b0, ovalid}, 32'd1);
        check({tag, " oRegWrite"}, {31'b0, oRegWrite}, 32'd0);
        check({tag, " oInstr"}, oInstr, instr);
    endtask

    task automatic readHiLo(input string tag, input logic [31:0] expHi,
                            input logic [31:0] expLo);
        setIn(MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
        @(posedge clock); #1;
        check({tag, " HI"}, oALUResult, expHi);
        setIn(MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
        @(posedge clock); #1;
        check({tag, " LO"}, oALUResult, expLo);
    endtask

    initial begin
        reset = 1'b1;
        iflush = 1'b0;
        setIn(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        check("reset ovalid", {31'b0, ovalid}, 32'd0);
        check("reset oALUResult", oALUResult, 32'd0);
        check("reset ostall", {31'b0, ostall}, 32'd0);
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;

        // ADD with immediate -1: 5 + (-1) = 4
        setIn(32'h20A2_FFFF, 32'd5, 32'h1234, 32'hFFFF_FFFF, 1'b1, 4'b0010,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
        stepAlu("add");
        check("add result", oALUResult, 32'd4);
        check("add zero", {31'b0, oZero}, 32'd0);
        check("add ovalid", {31'b0, ovalid}, 32'd1);
        check("add regwrite", {31'b0, oRegWrite}, 32'd1);
        check("add oB", oB, 32'h1234);
        check("add wreg", {27'b0, owriteRegWire}, 32'd2);

        // SUB to zero sets oZero
        setIn(32'h00E7_1022, 32'd7, 32'd7, 32'h0, 1'b0, 4'b0110,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
        stepAlu("sub");
        check("sub result", oALUResult, 32'd0);
        check("sub zero", {31'b0, oZero}, 32'd1);

        // SLT is signed: -1 < 1
        setIn(32'h00E7_102A, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 4'b0111,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
        stepAlu("slt");
        check("slt result", oALUResult, 32'd1);

        // NOR and an undefined control code
        setIn(32'h00E7_1027, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 1'b0, 4'b1100,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
        stepAlu("nor");
        check("nor result", oALUResult, 32'h0F0F_F0F0);
        setIn(32'h00E7_1027, 32'h1, 32'h2, 32'h0, 1'b0, 4'b0011,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
        stepAlu("undef");
        check("undef result", oALUResult, 32'd0);

        // Store controls pass through, then an invalid slot yields a bubble holding data
        setIn(32'hAC85_0010, 32'h100, 32'hCAFE, 32'h10, 1'b1, 4'b0010,
              1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
        stepAlu("sw");
        check("sw result", oALUResult, 32'h110);
        check("sw memwrite", {31'b0, oMemWrite}, 32'd1);
        setIn(32'h2222_2222, 32'd9, 32'd9, 32'h0, 1'b0, 4'b0010,
              1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        stepAlu("bubble");
        check("bubble ovalid", {31'b0, ovalid}, 32'd0);
        check("bubble instr", oInstr, 32'd0);
        check("bubble memwrite", {31'b0, oMemWrite}, 32'd0);
        check("bubble data kept", oALUResult, 32'h110);

        // Flush of a valid single-cycle op
        setIn(32'h20A2_0003, 32'd1, 32'd0, 32'd3, 1'b1, 4'b0010,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
        iflush = 1'b1;
        stepAlu("flush alu");
        iflush = 1'b0;
        check("flush alu ovalid", {31'b0, ovalid}, 32'd0);

        // Signed multiply -2 * 3 = -6, mfhi/mflo right after
        doMd("mult", MULT, 32'hFFFF_FFFE, 32'd3);
        readHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        doMd("div", DIV, 32'hFFFF_FFF9, 32'd2);
        readHiLo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        doMd("divu0", DIVU, 32'd9, 32'd0);
        readHiLo("divu0", 32'd9, 32'hFFFF_FFFF);

        doMd("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        readHiLo("divovf", 32'h0, 32'h8000_0000);

        doMd("div0s", DIV, 32'hFFFF_FFFB, 32'd0);
        readHiLo("div0s", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MULTU flushed in its 10th BUSY cycle: HI/LO keep the previous values
        setIn(MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 4'b0010,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(posedge clock);
        repeat (9) @(posedge clock);
        #1 iflush = 1'b1;
        @(negedge clock);
        check("mdflush stall", {31'b0, ostall}, 32'd0);
        @(posedge clock); #1;
        check("mdflush ovalid", {31'b0, ovalid}, 32'd0);
        check("mdflush instr", oInstr, 32'd0);
        iflush = 1'b0;
        ivalid = 1'b0;
        @(negedge clock);
        check("mdflush idle", {31'b0, ostall}, 32'd0);
        @(posedge clock); #1;
        readHiLo("mdflush", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Asynchronous reset between edges in the middle of a multiply
        setIn(MULT, 32'd7, 32'd6, 32'h0, 1'b0, 4'b0010,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        repeat (5) @(posedge clock);
        #3;
        ivalid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst stall", {31'b0, ostall}, 32'd0);
        check("rst result", oALUResult, 32'd0);
        check("rst instr", oInstr, 32'd0);
        check("rst oB", oB, 32'd0);
        check("rst ovalid", {31'b0, ovalid}, 32'd0);
        check("rst wreg", {27'b0, owriteRegWire}, 32'd0);
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;
        readHiLo("rst", 32'h0, 32'h0);

        doMd("mult2", MULT, 32'd7, 32'hFFFF_FFFA);
        readHiLo("mult2", 32'hFFFF_FFFF, 32'hFFFF_FFD6);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register. Consumes its decoded controls, operands and valid bit.
- Computes the ALU result for single-cycle operations.
- Runs an iterative 32-step multiply/divide unit into internal HI/LO registers, stalling upstream while busy.
- Registers the result and the surviving controls into the EX/MEM boundary for the memory stage.

Parameters:
- XLEN, 32, datapath width; the multiply/divide iteration count equals XLEN.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
iInstr  in  32  instruction word; funct is bits [5:0], opcode is bits [31:26]
iA  in  32  rs operand
iB  in  32  rt operand / store data
ioutSignEXT  in  32  sign-extended immediate
iALUSrc  in  1  1 selects ioutSignEXT as the second ALU operand
iALUCtrl  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR; other codes give result 0
iRegWrite, iMemRead, iMemWrite, iMemToReg  in  1 each  controls passed to MEM
iwriteRegWire  in  5  destination register
ivalid  in  1  the input instruction is real
iflush  in  1  kill the instruction in EX (branch resolved later)
oInstr  out  32  registered instruction
oALUResult  out  32  registered result
oZero  out  1  registered (oALUResult == 0)
oB  out  32  registered store data
owriteRegWire  out  5  registered destination
oRegWrite, oMemRead, oMemWrite, oMemToReg  out  1 each  registered controls
ovalid  out  1  registered valid
ostall  out  1  combinational; upstream must hold PC, IF/ID and ID/EX contents while high

Behaviour:
- Reset and state:
  - Reset (async) clears every output register, HI and LO to 0 and puts the FSM in IDLE.
  - A reset during BUSY abandons the operation; HI and LO become 0.
- MD-op decode: opcode 0 and funct 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU. mfhi is funct 0x10, mflo is funct 0x12.
- mfhi/mflo: the result is HI or LO; they bypass iALUCtrl.
- FSM states and transitions:
  - IDLE: if ivalid & MD-op & !iflush, latch operand magnitudes and sign flags, clear the step counter, go to BUSY. ostall = 1 in this cycle.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. ostall = 1.
    - counter == XLEN-1 goes to DONE.
    - iflush goes to IDLE immediately; HI/LO are unchanged.
  - DONE: ostall = 0. Apply sign correction and write HI/LO at the clock edge. Go to IDLE.
    - The held MD-op retires through the output register in this cycle; oRegWrite is forced to 0.
    - iflush in DONE suppresses the HI/LO write.
- MD-op timing: the instruction is first presented at edge E0. ostall is high for 33 cycles (IDLE detect plus 32 BUSY). The MD-op appears with ovalid = 1 after edge E0+34.
- Non-MD ops: 1-cycle latency, ostall = 0.
- Bubble rule: while ostall = 1, the output register loads a bubble. A bubble sets all controls, ovalid and oInstr to 0; data outputs keep their prior values.
- Flush rule: iflush = 1 (any state) loads a bubble at the next edge and sets ostall = 0.
- Signed MULT: the 64-bit product of magnitudes is negated when the operand signs differ. HI = [63:32], LO = [31:0].
- Signed DIV:
  - The quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - -2^31 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero (signed or unsigned): LO = 0xFFFFFFFF, HI = dividend, with the full 34-cycle latency.
- Arithmetic width rules: ADD/SUB wrap modulo 2^32 with no overflow trap. SLT is a signed compare producing 0 or 1.
- ivalid = 0: a bubble propagates and the FSM never starts.
- mfhi immediately after MULT: the value is already visible, because HI/LO are written on the same edge the MD-op leaves EX.

Test Plan:
- ADD with iA = 5, ALUSrc = 1, imm = 0xFFFFFFFF -> next edge: oALUResult = 4, oZero = 0, ovalid = 1, ostall never high.
- MULT with iA = 0xFFFFFFFE (-2), iB = 3 -> ostall high for exactly 33 cycles; at E0+34 ovalid = 1 and oRegWrite = 0; a following mfhi/mflo gives 0xFFFFFFFF / 0xFFFFFFFA.
- DIV with iA = -7, iB = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU with iB = 0 and iA = 9 -> LO = 0xFFFFFFFF, HI = 9.
- MULTU 0x10000 x 0x10000 with iflush asserted at the 10th BUSY cycle -> FSM returns to IDLE, ostall drops, a bubble is output, and HI/LO keep their prior values.
- Async reset pulsed mid-BUSY between clock edges -> ostall = 0, all outputs and HI/LO read 0 immediately; a fresh MULT afterwards completes correctly.
